// File: rtl/sqrt_result_collector_pkg.sv
// Shared constants, types and helpers for the sqrt result collector.
// No logic of its own; imported by the interface, the slot and the top.
// Pointer wrap is explicit so lane counts that are not powers of two work.
package sqrt_pipe_pkg;

    localparam int N_LANES = 8;
    localparam int RES_W   = 32;

    typedef logic [$clog2(N_LANES)-1:0] lane_idx_t;

    typedef struct packed {
        logic             pending;
        logic             full;
        logic [RES_W-1:0] data;
    } lane_slot_t;

    // Advance a ring pointer by one, wrapping from n-1 back to 0.
    function automatic int ptr_inc(input int p, input int n);
        return (p >= n - 1) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/sqrt_result_collector_if.sv
// Issue, per-lane capture and in-order delivery signals of the collector.
// slave is the collector's view; master is the dispatcher/worker/sink side.
// res_vld/res_rdy is a valid-ready handshake; issue_rdy gates issue_vld.
interface sqrt_result_collector_if
    import sqrt_pipe_pkg::*;
#(
    parameter int N = N_LANES,
    parameter int W = RES_W
);
    localparam int LW = $clog2(N);

    logic            issue_vld;
    logic            issue_rdy;
    logic [LW-1:0]   issue_lane;
    logic [N-1:0]    lane_vld;
    logic [N*W-1:0]  lane_res;
    logic            res_vld;
    logic            res_rdy;
    logic [W-1:0]    res;
    logic            err;

    modport slave (
        input  issue_vld, lane_vld, lane_res, res_rdy,
        output issue_rdy, issue_lane, res_vld, res, err
    );

    modport master (
        output issue_vld, lane_vld, lane_res, res_rdy,
        input  issue_rdy, issue_lane, res_vld, res, err
    );

endinterface

// File: rtl/sqrt_result_collector_slot.sv
// One lane's bookkeeping: pending after issue, full once its result lands.
// Capture registers on the clock after cap_vld; spurious is combinational.
// deq_clr frees the slot; it wins over capture so a bypassed result is dropped.
module collector_lane_slot
    import sqrt_pipe_pkg::*;
#(
    parameter int W = RES_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         issue_set,
    input  logic         cap_vld,
    input  logic [W-1:0] cap_data,
    input  logic         deq_clr,
    output logic         pending,
    output logic         full,
    output logic [W-1:0] data,
    output logic         spurious
);
    logic cap_ok;

    // A strobe is only meaningful while the lane is waiting for it.
    assign cap_ok   = cap_vld && pending;
    assign spurious = cap_vld && !pending;

    // Slot state: issue marks pending, capture moves pending to full, dequeue clears full.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
            full    <= 1'b0;
            data    <= '0;
        end else begin
            if (issue_set) begin
                pending <= 1'b1;
            end else if (cap_ok) begin
                pending <= 1'b0;
            end
            if (deq_clr) begin
                full <= 1'b0;
            end else if (cap_ok) begin
                full <= 1'b1;
            end
            if (cap_ok) begin
                data <= cap_data;
            end
        end
    end

endmodule

// File: rtl/sqrt_result_collector.sv
// Grants issue slots round-robin and returns lane results strictly in issue order.
// Latency lane_vld -> res_vld is 1 cycle (0 with SQRT_COLLECTOR_BYPASS_EN defined).
// res holds stable while res_rdy is low; issue stalls when the next lane is busy.
module sqrt_result_collector
    import sqrt_pipe_pkg::*;
#(
    parameter int N = N_LANES,
    parameter int W = RES_W
) (
    input  logic                  clk,
    input  logic                  rst,
    sqrt_result_collector_if.slave bus
);
    localparam int LW = $clog2(N);

    logic [LW-1:0] wr_ptr;
    logic [LW-1:0] rd_ptr;
    logic [N-1:0]  pending;
    logic [N-1:0]  full;
    logic [N-1:0]  spurious;
    logic [N-1:0]  issue_set;
    logic [N-1:0]  deq_clr;
    logic [W-1:0]  data [N];
    logic          issue_rdy;
    logic          issue_fire;
    logic          byp;
    logic          res_vld;
    logic          deq_fire;
    logic [W-1:0]  res;
    logic          err;

    for (genvar k = 0; k < N; k++) begin : g_slot
        collector_lane_slot #(.W(W)) u_slot (
            .clk      (clk),
            .rst      (rst),
            .issue_set(issue_set[k]),
            .cap_vld  (bus.lane_vld[k]),
            .cap_data (bus.lane_res[k*W +: W]),
            .deq_clr  (deq_clr[k]),
            .pending  (pending[k]),
            .full     (full[k]),
            .data     (data[k]),
            .spurious (spurious[k])
        );
    end

    // Next issue lane must be idle: no outstanding request and no undelivered result.
    assign issue_rdy  = !pending[wr_ptr] && !full[wr_ptr];
    assign issue_fire = bus.issue_vld && issue_rdy;

`ifdef SQRT_COLLECTOR_BYPASS_EN
    // Head lane returning into an empty slot may be forwarded straight out.
    assign byp = bus.lane_vld[rd_ptr] && pending[rd_ptr] && !full[rd_ptr];
`else
    assign byp = 1'b0;
`endif

    assign res_vld  = full[rd_ptr] || byp;
    assign deq_fire = res_vld && bus.res_rdy;

    // Output mux: stored head result first, forwarded lane input otherwise, zero when idle.
    always_comb begin
        res = '0;
        if (full[rd_ptr]) begin
            res = data[rd_ptr];
        end else if (byp) begin
            res = bus.lane_res[int'(rd_ptr)*W +: W];
        end
    end

    // Decode the two pointers into per-lane issue and dequeue strobes.
    always_comb begin
        issue_set = '0;
        deq_clr   = '0;
        for (int k = 0; k < N; k++) begin
            issue_set[k] = issue_fire && (wr_ptr == LW'(k));
            deq_clr[k]   = deq_fire && (rd_ptr == LW'(k));
        end
    end

    // Ring pointers and the sticky protocol-error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            err    <= 1'b0;
        end else begin
            if (issue_fire) begin
                wr_ptr <= LW'(ptr_inc(int'(wr_ptr), N));
            end
            if (deq_fire) begin
                rd_ptr <= LW'(ptr_inc(int'(rd_ptr), N));
            end
            if ((bus.issue_vld && !issue_rdy) || (|spurious)) begin
                err <= 1'b1;
            end
        end
    end

    assign bus.issue_rdy  = issue_rdy;
    assign bus.issue_lane = wr_ptr;
    assign bus.res_vld    = res_vld;
    assign bus.res        = res;
    assign bus.err        = err;

endmodule

// File: tb/tb_sqrt_result_collector.sv
// Directed bench: expected results queued at stimulus time, checked by a monitor.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
// Delivery cycle is checked where the test plan fixes the latency.
module tb_sqrt_result_collector;

`ifdef SQRT_COLLECTOR_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [31:0] d;
        int          c;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t q[$];

    sqrt_result_collector_if #(.N(8), .W(32)) bus ();

    sqrt_result_collector #(.N(8), .W(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every accepted result must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && bus.res_vld && bus.res_rdy) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_result: got %0h expected none (cycle %0d)", bus.res, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("res_data", bus.res, e.d);
                if (e.c >= 0) chk("res_cycle", cyc, e.c);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.issue_vld = 1'b0;
        bus.lane_vld  = '0;
        bus.lane_res  = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic issue_n(input int n);
        for (int i = 0; i < n; i++) begin
            bus.issue_vld = 1'b1;
            tick();
        end
        bus.issue_vld = 1'b0;
    endtask

    task automatic strobe(input int lane, input logic [31:0] v);
        bus.lane_vld = '0;
        bus.lane_res = '0;
        bus.lane_vld[lane] = 1'b1;
        bus.lane_res[lane*32 +: 32] = v;
        tick();
        bus.lane_vld = '0;
        bus.lane_res = '0;
    endtask

    task automatic chk_drained(input string name);
        chk(name, 32'(q.size()), 32'd0);
    endtask

    initial begin
        clear_inputs();
        bus.res_rdy = 1'b1;
        do_reset();

        // Reset state
        chk("rst_issue_rdy", 32'(bus.issue_rdy), 32'd1);
        chk("rst_issue_lane", 32'(bus.issue_lane), 32'd0);
        chk("rst_res_vld", 32'(bus.res_vld), 32'd0);
        chk("rst_res", bus.res, 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);

        // In-order return, one strobe per cycle
        issue_n(3);
        q.push_back('{32'h10, cyc + LAT});
        strobe(0, 32'h10);
        q.push_back('{32'h20, cyc + LAT});
        strobe(1, 32'h20);
        q.push_back('{32'h30, cyc + LAT});
        strobe(2, 32'h30);
        repeat (3) tick();
        chk_drained("inorder_drained");

        // Out-of-order return, head-of-line blocking
        do_reset();
        issue_n(4);
        strobe(3, 32'hD);
        chk("ooo_blocked_3", 32'(bus.res_vld), 32'd0);
        strobe(1, 32'hB);
        chk("ooo_blocked_1", 32'(bus.res_vld), 32'd0);
        strobe(2, 32'hC);
        chk("ooo_blocked_2", 32'(bus.res_vld), 32'd0);
        q.push_back('{32'hA, cyc + LAT});
        q.push_back('{32'hB, cyc + LAT + 1});
        q.push_back('{32'hC, cyc + LAT + 2});
        q.push_back('{32'hD, cyc + LAT + 3});
        strobe(0, 32'hA);
        repeat (5) tick();
        chk_drained("ooo_drained");
        chk("ooo_err", 32'(bus.err), 32'd0);

        // Backpressure with every lane occupied
        do_reset();
        bus.res_rdy = 1'b0;
        issue_n(8);
        chk("full_issue_rdy", 32'(bus.issue_rdy), 32'd0);
        bus.lane_vld = '1;
        for (int k = 0; k < 8; k++) begin
            bus.lane_res[k*32 +: 32] = 32'h100 + 32'(k);
            q.push_back('{32'h100 + 32'(k), -1});
        end
        tick();
        clear_inputs();
        for (int i = 0; i < 5; i++) begin
            chk("bp_issue_rdy", 32'(bus.issue_rdy), 32'd0);
            chk("bp_res_vld", 32'(bus.res_vld), 32'd1);
            chk("bp_res_hold", bus.res, 32'h100);
            tick();
        end
        bus.res_rdy = 1'b1;
        chk("bp_issue_rdy_pre", 32'(bus.issue_rdy), 32'd0);
        tick();
        chk("bp_issue_rdy_post", 32'(bus.issue_rdy), 32'd1);
        chk("bp_issue_lane_post", 32'(bus.issue_lane), 32'd0);
        repeat (9) tick();
        chk_drained("bp_drained");

        // Pointer wrap over 20 issue/return pairs
        do_reset();
        for (int i = 0; i < 20; i++) begin
            chk("wrap_issue_lane", 32'(bus.issue_lane), 32'(i % 8));
            issue_n(1);
            q.push_back('{32'h1000 + 32'(i), cyc + LAT});
            strobe(i % 8, 32'h1000 + 32'(i));
        end
        repeat (3) tick();
        chk_drained("wrap_drained");
        chk("wrap_final_lane", 32'(bus.issue_lane), 32'd4);
        chk("wrap_err", 32'(bus.err), 32'd0);

        // Spurious strobe
        do_reset();
        chk("err_clear_a", 32'(bus.err), 32'd0);
        strobe(5, 32'h55);
        chk("spurious_err", 32'(bus.err), 32'd1);
        chk("spurious_res_vld", 32'(bus.res_vld), 32'd0);

        // Issue while not ready
        do_reset();
        chk("err_clear_b", 32'(bus.err), 32'd0);
        bus.res_rdy = 1'b0;
        issue_n(8);
        chk("full_no_err", 32'(bus.err), 32'd0);
        issue_n(1);
        chk("overissue_err", 32'(bus.err), 32'd1);
        chk("overissue_lane", 32'(bus.issue_lane), 32'd0);
        do_reset();
        chk("err_clear_c", 32'(bus.err), 32'd0);

        // Reset with work in flight
        issue_n(6);
        strobe(0, 32'h77);
        strobe(1, 32'h88);
        chk("mid_res_vld_pre", 32'(bus.res_vld), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_res_vld", 32'(bus.res_vld), 32'd0);
        chk("mid_issue_rdy", 32'(bus.issue_rdy), 32'd1);
        chk("mid_issue_lane", 32'(bus.issue_lane), 32'd0);
        chk("mid_err_clear", 32'(bus.err), 32'd0);
        strobe(2, 32'h99);
        chk("mid_late_err", 32'(bus.err), 32'd1);
        chk("mid_late_res_vld", 32'(bus.res_vld), 32'd0);
        chk_drained("final_drained");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sqrt_result_collector.md
Name: sqrt_result_collector

Overview:
- Return-path partner of the round-robin sqrt-formula distributor.
- Grants issue slots to N worker lanes and tracks one outstanding request per lane.
- Captures each lane's result whenever it arrives, in any order and with any latency.
- Delivers results strictly in issue order over a valid/ready output handshake, so downstream sees a single in-order stream with backpressure.

Parameters:
- N, 8, number of worker lanes (≥2).
- W, 32, result width.
- LW, $clog2(N), lane index width (derived; not overridable).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- issue_vld  in  1  dispatcher issues an argument this cycle to lane issue_lane
- issue_rdy  out  1  lane at issue_lane is free (not pending, slot empty)
- issue_lane  out  LW  lane index the next issue goes to (internal wr_ptr)
- lane_vld  in  N  per-lane result strobe from worker instances
- lane_res  in  N*W  per-lane results, lane k at bits [k*W +: W]
- res_vld  out  1  in-order result available
- res_rdy  in  1  downstream accepts the result
- res  out  W  in-order result data
- err  out  1  sticky protocol-error flag

Behaviour:
- Per-lane state: pending (issued, no result yet), full (result stored, not yet delivered), data[W].
- Pointers:
  - wr_ptr (issue) and rd_ptr (delivery) are both LW-bit.
  - Each increments by one and wraps from N-1 to 0; non-power-of-2 N wraps explicitly.
- Reset values: wr_ptr=0, rd_ptr=0, all pending=0, all full=0, data=0. Outputs after reset: issue_rdy=1, issue_lane=0, res_vld=0, res=0, err=0.
- Issue path:
  - issue_rdy = !pending[wr_ptr] & !full[wr_ptr], computed from registered state only.
  - Issue fires on issue_vld & issue_rdy: set pending[wr_ptr], wr_ptr++.
  - issue_vld while !issue_rdy is ignored: no state change, err set.
- Capture path:
  - lane_vld[k] with pending[k]=1: next cycle full[k]=1, data[k]=lane_res[k], pending[k]=0.
  - lane_vld[k] with pending[k]=0 (spurious or duplicate): data discarded, err set.
  - Multiple lanes may strobe in the same cycle; all are captured.
- Delivery path:
  - res_vld = full[rd_ptr]; res = data[rd_ptr] when res_vld, else 0.
  - Delivery fires on res_vld & res_rdy: full[rd_ptr] cleared, rd_ptr++.
  - While res_vld & !res_rdy, res and res_vld hold stable.
- Latency: lane_vld to res_vld is 1 cycle when that lane is the head and its slot was empty.
- Ordering: a late lane blocks delivery of later lanes that have already completed (head-of-line). Their slots stay full, so issue stalls on them.
- Simultaneous events:
  - Issue to lane k and delivery from lane k in the same cycle cannot occur, because issue_rdy requires full[k]=0.
  - A lane freed by delivery becomes issuable the next cycle.
  - Capture and delivery on different lanes in the same cycle proceed independently.
- Full condition: all N lanes pending or full → issue_rdy=0.
- Empty condition: no lane full at rd_ptr → res_vld=0.
- Reset mid-operation: all pending and stored results are dropped and pointers return to 0. Lane results arriving after reset are flagged as spurious (err=1).
- err is sticky and is cleared only by rst.

Optional Feature:
- Macro: SQRT_COLLECTOR_BYPASS_EN.
- Defined:
  - If lane_vld[rd_ptr] & pending[rd_ptr] & !full[rd_ptr], then res_vld=1 and res=lane_res[rd_ptr] in the same cycle (zero-latency path).
  - If res_rdy is also 1, the result is consumed without being stored and rd_ptr++.
  - Otherwise it is stored as normal.
  - Adds a combinational path from lane inputs to outputs.
- Undefined: res is fully registered and the minimum latency is 1 cycle.

Decomposition:
- Package sqrt_pipe_pkg:
  - lane-count and width constants (N_LANES=8, RES_W=32)
  - lane_idx_t typedef
  - lane_slot_t struct {pending, full, data}
  - ptr_inc function with wrap
- Sub-module collector_lane_slot, one instance per lane.
  - Inputs: issue_set, cap_vld, cap_data, deq_clr.
  - Outputs: pending, full, data, spurious.
- Top level holds the pointers, the output mux, issue_rdy and the err logic.

Test Plan:
- In-order: after reset, issue 3 times, lanes 0,1,2 return 0x10,0x20,0x30 one per cycle with res_rdy=1 → res sequence 0x10,0x20,0x30, each 1 cycle after its strobe.
- Out-of-order: issue lanes 0-3; lanes return in order 3,1,2,0 with values 0xD,0xB,0xC,0xA → res_vld stays 0 until lane 0 returns, then 0xA,0xB,0xC,0xD on consecutive cycles.
- Backpressure and full: N=8, issue 8, all lanes return, res_rdy=0 for 5 cycles.
  - issue_rdy=0 throughout.
  - res holds lane-0 data stable.
  - Releasing res_rdy drains all 8 in order; issue_rdy rises the cycle after the first delivery, with issue_lane=0.
- Wrap: 20 issue/return pairs → issue_lane and delivery wrap 7→0 with no loss.
- Errors:
  - lane_vld[5] with no issue → err=1 and no res_vld.
  - issue_vld when issue_rdy=0 → err=1 and wr_ptr unchanged.
  - rst clears err.
- Reset mid-flight: 4 pending plus 2 full, assert rst → next cycle res_vld=0, issue_rdy=1, issue_lane=0; a lane-2 strobe afterwards sets err.
- With SQRT_COLLECTOR_BYPASS_EN, repeat the in-order case → res_vld is asserted in the same cycle as lane_vld.
